// File: rtl/csa_task_gen.sv
// Splits a key range into fixed-size jobs and writes each as a 5-word record into the CSA input FIFO.
// Optional: define CSA_TASK_GEN_STALL_CNT_EN to add the stall_count backpressure counter output.
module csa_task_gen #(
    parameter int unsigned AXI_DATA_WIDTH    = 32,
    parameter int unsigned CSA_CALC_IN_WIDTH = 48,
    parameter logic [AXI_DATA_WIDTH-1:0] TIMES_START_VALUE = '0
) (
    input  logic                         csa_in_wclk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic [CSA_CALC_IN_WIDTH-1:0] cfg_key_start,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_total,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_chunk,
    input  logic [AXI_DATA_WIDTH-1:0]    cfg_block_base,
    input  logic                         csa_in_error_full,
    output logic                         csa_in_wen,
    output logic [AXI_DATA_WIDTH-1:0]    csa_in_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_error,
    output logic [AXI_DATA_WIDTH-1:0]    block_count
`ifdef CSA_TASK_GEN_STALL_CNT_EN
    ,
    output logic [AXI_DATA_WIDTH-1:0]    stall_count
`endif
);

    typedef enum logic [3:0] {
        IDLE, CHECK, W0, W1, W2, W3, W4, NEXT, FINISH
    } state_t;

    localparam logic [AXI_DATA_WIDTH-1:0] ONE = AXI_DATA_WIDTH'(1);

    state_t                         state, next_state;
    logic [CSA_CALC_IN_WIDTH-1:0]   key;
    logic [AXI_DATA_WIDTH-1:0]      remaining;
    logic [AXI_DATA_WIDTH-1:0]      blk;
    logic [AXI_DATA_WIDTH-1:0]      chunk;
    logic [AXI_DATA_WIDTH-1:0]      times;
    logic [AXI_DATA_WIDTH-1:0]      times_next;
    logic                           stop_pending;
    logic                           accept;

    assign accept     = (state == IDLE) && start && (cfg_chunk != '0);
    assign times_next = (chunk < remaining) ? chunk : remaining;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CHECK;
            CHECK: begin
                if ((remaining == '0) || stop_pending) next_state = FINISH;
                else if (!csa_in_error_full)           next_state = W0;
            end
            W0:      next_state = W1;
            W1:      next_state = W2;
            W2:      next_state = W3;
            W3:      next_state = W4;
            W4:      next_state = NEXT;
            NEXT:    next_state = CHECK;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so wen/wdata line up with the Wx states.
    always_ff @(posedge csa_in_wclk) begin
        if (!rst_n) begin
            state        <= IDLE;
            key          <= '0;
            remaining    <= '0;
            blk          <= '0;
            chunk        <= '0;
            times        <= '0;
            stop_pending <= 1'b0;
            csa_in_wen   <= 1'b0;
            csa_in_wdata <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_error    <= 1'b0;
            block_count  <= '0;
        end else begin
            state      <= next_state;
            busy       <= (next_state != IDLE);
            done       <= (next_state == FINISH);
            cfg_error  <= (state == IDLE) && start && (cfg_chunk == '0);
            csa_in_wen <= (next_state inside {W0, W1, W2, W3, W4});

            case (next_state)
                W0:      csa_in_wdata <= blk;
                W1:      csa_in_wdata <= key[AXI_DATA_WIDTH-1:0];
                W2:      csa_in_wdata <= AXI_DATA_WIDTH'(key >> AXI_DATA_WIDTH);
                W3:      csa_in_wdata <= times;
                W4:      csa_in_wdata <= TIMES_START_VALUE;
                default: csa_in_wdata <= csa_in_wdata;
            endcase

            if (accept) begin
                key         <= cfg_key_start;
                remaining   <= cfg_total;
                blk         <= cfg_block_base;
                chunk       <= cfg_chunk;
                block_count <= '0;
            end

            if ((state == CHECK) && (next_state == W0)) times <= times_next;

            if (state == NEXT) begin
                key         <= key + CSA_CALC_IN_WIDTH'(times);
                remaining   <= remaining - times;
                blk         <= blk + ONE;
                block_count <= block_count + ONE;
            end

            if (state == FINISH)                 stop_pending <= 1'b0;
            else if ((state != IDLE) && stop)    stop_pending <= 1'b1;
        end
    end

`ifdef CSA_TASK_GEN_STALL_CNT_EN
    always_ff @(posedge csa_in_wclk) begin
        if (!rst_n || accept) begin
            stall_count <= '0;
        end else if ((state == CHECK) && csa_in_error_full && (remaining != '0)
                     && !stop_pending && (stall_count != '1)) begin
            stall_count <= stall_count + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_csa_task_gen.sv
// Directed bench for csa_task_gen: a queue-based record model checked against every FIFO write.
module tb_csa_task_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stop, full;
    logic [47:0] cfg_key_start;
    logic [31:0] cfg_total, cfg_chunk, cfg_block_base;
    logic        wen, busy, done, cfg_error;
    logic [31:0] wdata, block_count;
`ifdef CSA_TASK_GEN_STALL_CNT_EN
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    csa_task_gen #(
        .AXI_DATA_WIDTH(32),
        .CSA_CALC_IN_WIDTH(48),
        .TIMES_START_VALUE(32'd0)
    ) dut (
        .csa_in_wclk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .cfg_key_start(cfg_key_start),
        .cfg_total(cfg_total),
        .cfg_chunk(cfg_chunk),
        .cfg_block_base(cfg_block_base),
        .csa_in_error_full(full),
        .csa_in_wen(wen),
        .csa_in_wdata(wdata),
        .busy(busy),
        .done(done),
        .cfg_error(cfg_error),
        .block_count(block_count)
`ifdef CSA_TASK_GEN_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cap_q[$];
    int start_q[$];
    int cyc = 0;
    int widx = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected record stream: one 5-word record per job until the range (or record limit) is used up.
    task automatic gen_model(input logic [47:0] k0, input logic [31:0] total, input logic [31:0] chunk,
                             input logic [31:0] base, input int max_recs);
        logic [47:0] k;
        logic [31:0] rem, t, b;
        int n;
        k = k0; rem = total; b = base; n = 0;
        while (rem != 0 && n < max_recs) begin
            t = (chunk < rem) ? chunk : rem;
            exp_q.push_back(b);
            exp_q.push_back(k[31:0]);
            exp_q.push_back({16'b0, k[47:32]});
            exp_q.push_back(t);
            exp_q.push_back(32'd0);
            k = k + {16'b0, t};
            rem = rem - t;
            b = b + 1;
            n++;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            widx = 0;
        end else begin
            if (wen) begin
                cap_q.push_back(wdata);
                if (widx == 0) start_q.push_back(cyc);
            end
            if (exp_q.size() == 0) begin
                check32("spurious_wen", {31'b0, wen}, 32'd0);
            end else if (wen) begin
                check32($sformatf("rec_word%0d", widx), wdata, exp_q.pop_front());
                widx = (widx + 1) % 5;
            end else if (widx != 0) begin
                check32("gap_in_record", {31'b0, wen}, 32'd1);
            end
        end
    end

    task automatic do_start(input logic [47:0] k, input logic [31:0] total, input logic [31:0] chunk,
                            input logic [31:0] base);
        cap_q.delete();
        start_q.delete();
        @(posedge clk); #1;
        cfg_key_start = k; cfg_total = total; cfg_chunk = chunk; cfg_block_base = base;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!done && n < limit);
        check32("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic wait_words(input int count, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (cap_q.size() < count && n < limit);
        check32("words_reached", cap_q.size(), count);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; full = 1'b0;
        cfg_key_start = '0; cfg_total = '0; cfg_chunk = '0; cfg_block_base = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_wen", {31'b0, wen}, 32'd0);
        check32("rst_busy", {31'b0, busy}, 32'd0);
        check32("rst_done", {31'b0, done}, 32'd0);
        check32("rst_wdata", wdata, 32'd0);
        check32("rst_block_count", block_count, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic run
        gen_model(48'd1, 32'd30, 32'd10, 32'd1, 100);
        check32("model_rec2_blk", exp_q[5], 32'd2);
        check32("model_rec2_key", exp_q[6], 32'd11);
        check32("model_rec3_key", exp_q[11], 32'd21);
        do_start(48'd1, 32'd30, 32'd10, 32'd1);
        @(negedge clk);
        check32("lat_check_wen", {31'b0, wen}, 32'd0);
        check32("lat_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check32("lat_first_wen", {31'b0, wen}, 32'd1);
        wait_done(200);
        check32("basic_block_count", block_count, 32'd3);
        check32("basic_exp_drained", exp_q.size(), 32'd0);
        check32("basic_rec_pitch1", start_q[1] - start_q[0], 32'd7);
        check32("basic_rec_pitch2", start_q[2] - start_q[1], 32'd7);
        check32("basic_rec3_blk", cap_q[10], 32'd3);
        check32("basic_rec3_key", cap_q[11], 32'd21);
        @(negedge clk);
        check32("done_one_cycle", {31'b0, done}, 32'd0);
        check32("basic_busy_after", {31'b0, busy}, 32'd0);

        // Partial tail
        gen_model(48'd100, 32'd25, 32'd10, 32'd7, 100);
        do_start(48'd100, 32'd25, 32'd10, 32'd7);
        wait_done(200);
        check32("tail_times1", cap_q[3], 32'd10);
        check32("tail_times3", cap_q[13], 32'd5);
        check32("tail_key2", cap_q[6], 32'd110);
        check32("tail_key3", cap_q[11], 32'd120);
        check32("tail_block_count", block_count, 32'd3);

        // Key carry and wrap
        gen_model(48'hFFFF_FFFF_FFFE, 32'd8, 32'd4, 32'd0, 100);
        do_start(48'hFFFF_FFFF_FFFE, 32'd8, 32'd4, 32'd0);
        wait_done(200);
        check32("wrap_r1_lo", cap_q[1], 32'hFFFF_FFFE);
        check32("wrap_r1_hi", cap_q[2], 32'h0000_FFFF);
        check32("wrap_r2_lo", cap_q[6], 32'h0000_0002);
        check32("wrap_r2_hi", cap_q[7], 32'h0000_0000);

        // Backpressure: 20 stalled CHECK cycles before record 2
        gen_model(48'd0, 32'd20, 32'd10, 32'd0, 100);
        do_start(48'd0, 32'd20, 32'd10, 32'd0);
        begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (!wen && n < 10);
            check32("bp_first_wen", {31'b0, wen}, 32'd1);
        end
        @(posedge clk); #1 full = 1'b1;
        repeat (25) @(posedge clk);
        #1 full = 1'b0;
        wait_done(200);
        check32("bp_rec2_delay", start_q[1] - start_q[0], 32'd27);
        check32("bp_words", cap_q.size(), 32'd10);
`ifdef CSA_TASK_GEN_STALL_CNT_EN
        check32("bp_stall_count", stall_count, 32'd20);
`endif

        // Stop during W2 of record 2
        gen_model(48'd0, 32'd100, 32'd10, 32'd0, 2);
        do_start(48'd0, 32'd100, 32'd10, 32'd0);
        wait_words(8, 60);
        stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done(200);
        check32("stop_block_count", block_count, 32'd2);
        check32("stop_words", cap_q.size(), 32'd10);

        // Zero chunk is rejected
        do_start(48'd0, 32'd30, 32'd0, 32'd0);
        @(negedge clk);
        check32("cfgerr_pulse", {31'b0, cfg_error}, 32'd1);
        check32("cfgerr_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check32("cfgerr_one_cycle", {31'b0, cfg_error}, 32'd0);
        check32("cfgerr_busy2", {31'b0, busy}, 32'd0);

        // Zero total: done two cycles after start, no records
        do_start(48'd0, 32'd0, 32'd10, 32'd0);
        @(negedge clk);
        check32("zero_done_early", {31'b0, done}, 32'd0);
        @(negedge clk);
        check32("zero_done", {31'b0, done}, 32'd1);
        check32("zero_block_count", block_count, 32'd0);

        // Reset during W3 of record 2, then replay
        repeat (2) @(posedge clk);
        gen_model(48'd0, 32'd30, 32'd10, 32'd5, 100);
        do_start(48'd0, 32'd30, 32'd10, 32'd5);
        wait_words(8, 60);
        check32("mid_block_count", block_count, 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check32("midrst_wen", {31'b0, wen}, 32'd0);
        check32("midrst_busy", {31'b0, busy}, 32'd0);
        check32("midrst_block_count", block_count, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        gen_model(48'd0, 32'd30, 32'd10, 32'd5, 100);
        do_start(48'd0, 32'd30, 32'd10, 32'd5);
        wait_done(200);
        check32("replay_first_blk", cap_q[0], 32'd5);
        check32("replay_block_count", block_count, 32'd3);
        check32("replay_exp_drained", exp_q.size(), 32'd0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
